// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with tick-qualified decrement, sensor hold,
// one-cycle done pulse and per-digit borrow flags for the display path.
module bcd_countdown_timer #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SEXAGESIMAL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  paused,
    output logic                  zero,
    output logic                  done,
    output logic [DIGITS-1:0]     borrow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t state;

    logic [4*DIGITS-1:0] dec_value;
    logic [DIGITS-1:0]   dec_borrow;
    logic                dec_zero;
    logic                chain;

    // Odd digits are tens of seconds/minutes in sexagesimal mode.
    function automatic logic [3:0] digit_max(input int unsigned idx);
        return ((SEXAGESIMAL != 0) && (idx % 2 == 1)) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > digit_max(i)) begin
                r[4*i +: 4] = digit_max(i);
            end
        end
        return r;
    endfunction

    assign zero = (count == '0);

    // Whole borrow chain resolves in one cycle, so no digit ever holds an invalid code.
    always_comb begin
        dec_value  = count;
        dec_borrow = '0;
        chain      = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_value[4*i +: 4] = digit_max(i);
                    dec_borrow[i]       = 1'b1;
                end else begin
                    dec_value[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    chain               = 1'b0;
                end
            end
        end
        dec_zero = (dec_value == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            state   <= S_IDLE;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
            borrow  <= '0;
        end else begin
            done   <= 1'b0;
            borrow <= '0;
            if (load) begin
                count   <= clamp_bcd(load_value);
                state   <= S_IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
            end else if (stop) begin
                state   <= S_IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !zero) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (hold) begin
                            state   <= S_PAUSED;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end else if (tick && !zero) begin
                            count  <= dec_value;
                            borrow <= dec_borrow;
                            if (dec_zero) begin
                                state   <= S_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        // Resume only; a tick coincident with hold release is dropped.
                        if (!hold) begin
                            state   <= S_RUN;
                            paused  <= 1'b0;
                            running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                    end
                    default: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                        paused  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: sexagesimal and decimal instances share stimulus
// and are compared each cycle against a seconds-valued reference model.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        hold = 1'b0;

    logic [15:0] count0, count1;
    logic        running0, running1, paused0, paused1;
    logic        zero0, zero1, done0, done1;
    logic [3:0]  borrow0, borrow1;

    int n_cmp = 0;
    int n_err = 0;

    // model state: 0 idle, 1 run, 2 paused, 3 done; value is a plain count of units
    int m_val[2];
    int m_st[2];
    int m_done[2];
    int m_borrow[2];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(4), .SEXAGESIMAL(1)) dut_sex (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .hold(hold), .count(count0), .running(running0),
        .paused(paused0), .zero(zero0), .done(done0), .borrow(borrow0)
    );

    bcd_countdown_timer #(.DIGITS(4), .SEXAGESIMAL(0)) dut_dec (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .hold(hold), .count(count1), .running(running1),
        .paused(paused1), .zero(zero1), .done(done1), .borrow(borrow1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int radix(input int inst, input int i);
        return (inst == 0 && (i % 2) == 1) ? 6 : 10;
    endfunction

    function automatic int weight(input int inst, input int n);
        int w = 1;
        for (int i = 0; i < n; i++) w = w * radix(inst, i);
        return w;
    endfunction

    function automatic int to_val(input int inst, input logic [15:0] bcd);
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'(bcd[4*i +: 4]);
            if (d > radix(inst, i) - 1) d = radix(inst, i) - 1;
            v = v + d * weight(inst, i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int inst, input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % radix(inst, i));
            t = t / radix(inst, i);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_st[k] = 0; m_done[k] = 0; m_borrow[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            m_borrow[k] = 0;
            if (load) begin
                m_val[k] = to_val(k, load_value);
                m_st[k] = 0;
            end else if (stop) begin
                m_st[k] = 0;
            end else begin
                case (m_st[k])
                    0: if (start && m_val[k] != 0) m_st[k] = 1;
                    1: begin
                        if (hold) m_st[k] = 2;
                        else if (tick && m_val[k] != 0) begin
                            // digit i wraps exactly when digits 0..i are all zero
                            for (int i = 0; i < 4; i++)
                                if (m_val[k] % weight(k, i + 1) == 0) m_borrow[k] |= (1 << i);
                            m_val[k] = m_val[k] - 1;
                            if (m_val[k] == 0) begin
                                m_st[k] = 3;
                                m_done[k] = 1;
                            end
                        end
                    end
                    2: if (!hold) m_st[k] = 1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all();
        check("count_s",   32'(count0),   32'(to_bcd(0, m_val[0])));
        check("zero_s",    32'(zero0),    32'(m_val[0] == 0));
        check("running_s", 32'(running0), 32'(m_st[0] == 1));
        check("paused_s",  32'(paused0),  32'(m_st[0] == 2));
        check("done_s",    32'(done0),    32'(m_done[0]));
        check("borrow_s",  32'(borrow0),  32'(m_borrow[0]));
        check("count_d",   32'(count1),   32'(to_bcd(1, m_val[1])));
        check("zero_d",    32'(zero1),    32'(m_val[1] == 0));
        check("running_d", 32'(running1), 32'(m_st[1] == 1));
        check("paused_d",  32'(paused1),  32'(m_st[1] == 2));
        check("done_d",    32'(done1),    32'(m_done[1]));
        check("borrow_d",  32'(borrow1),  32'(m_borrow[1]));
    endtask

    task automatic cycle(input logic ld, input logic [15:0] lv, input logic stp,
                         input logic st, input logic hd, input logic tk);
        load = ld; load_value = lv; stop = stp; start = st; hold = hd; tick = tk;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},   32'(count0),   32'h0);
        check({tag, "_zero"},    32'(zero0),    32'h1);
        check({tag, "_running"}, 32'(running0), 32'h0);
        check({tag, "_paused"},  32'(paused0),  32'h0);
        check({tag, "_done"},    32'(done0),    32'h0);
        check({tag, "_borrow"},  32'(borrow0),  32'h0);
    endtask

    initial begin
        bit hold_r;
        model_reset();
        load = 1'b1; load_value = 16'h0130;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1, 16'h0130, 0, 0, 0, 0);
        check("load_0130", 32'(count0), 32'h0130);

        // mixed-radix wrap
        cycle(1, 16'h1000, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("wrap_s", 32'(count0), 32'h0959);
        check("wrap_borrow_s", 32'(borrow0), 32'h7);
        check("wrap_d", 32'(count1), 32'h0999);
        cycle(0, 16'h0, 0, 0, 0, 0);
        check("borrow_clear", 32'(borrow0), 32'h0);

        // completion
        cycle(1, 16'h0002, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("done_early", 32'(done0), 32'h0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("done_pulse", 32'(done0), 32'h1);
        check("done_count", 32'(count0), 32'h0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("done_once", 32'(done0), 32'h0);
        cycle(0, 16'h0, 0, 1, 0, 1);
        check("done_sticky_run", 32'(running0), 32'h0);

        // hold
        cycle(1, 16'h0105, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 1, 0, 0);
        repeat (3) cycle(0, 16'h0, 0, 0, 1, 1);
        check("hold_count", 32'(count0), 32'h0105);
        check("hold_paused", 32'(paused0), 32'h1);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("resume_no_dec", 32'(count0), 32'h0105);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("resume_dec", 32'(count0), 32'h0104);
        check("resume_running", 32'(running0), 32'h1);

        // load beats tick, with clamping
        cycle(1, 16'h0A7F, 0, 0, 0, 1);
        check("clamp_s", 32'(count0), 32'h0959);
        check("clamp_d", 32'(count1), 32'h0979);
        cycle(0, 16'h0, 0, 1, 0, 0);
        cycle(0, 16'h0, 1, 1, 0, 0);
        check("stop_start", 32'(running0), 32'h0);

        // async reset between edges
        cycle(0, 16'h0, 0, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async");
        #2 rst_n = 1'b1;
        cycle(1, 16'h0100, 0, 0, 0, 0);
        cycle(0, 16'h0, 0, 1, 0, 0);
        cycle(0, 16'h0, 0, 0, 0, 1);
        check("dec_0099", 32'(count1), 32'h0099);
        check("sex_0059", 32'(count0), 32'h0059);

        // randomized phase
        hold_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic ld, stp, st, tk;
            logic [15:0] lv;
            ld  = ($urandom_range(0, 99) < 4);
            lv  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0012));
            stp = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 25);
            tk  = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 10) hold_r = ~hold_r;
            cycle(ld, lv, stp, st, hold_r, tk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
